pll_lock_sequencer: RTL
=======================

Name: pll_lock_sequencer

Overview:
- Controller for the SB_PLL40_CORE clock path. Runs on the PLL reference clock (HFOSC 48 MHz) and drives PLL RESETB/BYPASS.
- Qualifies the asynchronous LOCK output and holds the PLL-clocked logic in reset until lock is stable.
- Recovers from lock loss; after repeated lock failures, falls back to bypass (reference clock passes through).
- Sits between the oscillator/PLL primitives and the counter/LED logic in top-level designs.

Parameters:
- RST_CYCLES, 16: cycles pll_resetb is held low per attempt (>=1).
- LOCK_TIMEOUT, 4096: cycles allowed in WAIT_LOCK before an attempt fails (>=1).
- SETTLE_CYCLES, 1024: consecutive synchronized-lock-high cycles required before RUN (>=1).
- LOSS_FILTER, 4: consecutive synchronized-lock-low cycles in RUN that count as lock loss (>=1).
- MAX_RETRIES, 3: failed attempts retried before FAULT; total attempts = MAX_RETRIES+1.

Ports:
- clk, in, 1: reference clock (same clock as PLL REFERENCECLK).
- rst, in, 1: synchronous, active-high reset.
- pll_lock, in, 1: PLL LOCK; asynchronous to clk.
- relock_req, in, 1: single-cycle pulse; restarts the sequence from RUN or FAULT.
- pll_resetb, out, 1: to PLL RESETB; active low.
- pll_bypass, out, 1: to PLL BYPASS.
- domain_rst, out, 1: active-high reset for PLL-clocked logic.
- locked, out, 1: high only in RUN.
- fault, out, 1: high only in FAULT.
- state, out, 3: current state encoding.
- retry_cnt, out, $clog2(MAX_RETRIES+1): failed attempts since the last RUN or relock.
- loss_cnt, out, 8: lock-loss events; saturates at 255.

Behaviour:
- Synchronizer: pll_lock passes through 2 flops to give lock_s (2-cycle latency). Only lock_s is used.
- State encodings: RESET_PLL=0, WAIT_LOCK=1, SETTLE=2, RUN=3, FAULT=4. Codes 5-7 are illegal and go to RESET_PLL.
- All outputs are registers updated on the same edge as the state register. Each output is a fixed function of state, apart from the counters.
- Output values per state:
  - RESET_PLL: pll_resetb=0, bypass=0, domain_rst=1, locked=0, fault=0.
  - WAIT_LOCK and SETTLE: pll_resetb=1, bypass=0, domain_rst=1, locked=0, fault=0.
  - RUN: pll_resetb=1, bypass=0, domain_rst=0, locked=1, fault=0.
  - FAULT: pll_resetb=0, bypass=1, domain_rst=0, locked=0, fault=1.
- Reset (rst=1 at a clk edge):
  - state=RESET_PLL with RESET_PLL outputs.
  - retry_cnt=0, loss_cnt=0, internal timers=0, synchronizer flops=0.
  - rst mid-operation aborts any state on that edge.
- RESET_PLL: stays exactly RST_CYCLES cycles, then goes to WAIT_LOCK. The timer clears on entry.
- WAIT_LOCK:
  - lock_s=1 -> SETTLE, settle count = 0.
  - If lock_s stays 0 for LOCK_TIMEOUT cycles:
    - retry_cnt < MAX_RETRIES -> retry_cnt++, go to RESET_PLL.
    - retry_cnt == MAX_RETRIES -> FAULT.
- SETTLE:
  - Count consecutive lock_s=1 cycles. After SETTLE_CYCLES of them -> RUN, retry_cnt cleared.
  - Any lock_s=0 -> WAIT_LOCK with a fresh timeout timer. retry_cnt is unchanged; this is not a failed attempt.
- RUN:
  - Track consecutive lock_s=0 cycles; any lock_s=1 clears the run.
  - On reaching LOSS_FILTER -> RESET_PLL, loss_cnt++ (saturating).
  - Shorter glitches have no effect.
- FAULT: held until relock_req or rst.
- relock_req:
  - Honoured only in RUN or FAULT. Effect: RESET_PLL on the next edge, retry_cnt=0, fault=0.
  - Ignored in RESET_PLL, WAIT_LOCK and SETTLE.
  - If relock_req and lock loss qualify on the same edge in RUN, relock wins and loss_cnt does not increment.
- Counter widths: each counter is sized with $clog2 of its limit, +1. No wrap is possible.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=32, SETTLE_CYCLES=8, LOSS_FILTER=3, MAX_RETRIES=2):
- Nominal lock:
  - Stimulus: release rst; assert pll_lock 5 cycles after pll_resetb rises.
  - Response: SETTLE 2 cycles later, then RUN after 8 more. domain_rst falls and locked rises on the same edge. retry_cnt=0.
- No lock:
  - Stimulus: pll_lock held 0.
  - Response: pll_resetb pulses low 3 times, 4 cycles each. retry_cnt goes 1 then 2. FAULT is entered 108 cycles after rst release, with pll_bypass=1, pll_resetb=0, domain_rst=0, fault=1.
- Lock glitch in RUN:
  - Stimulus: in RUN, pll_lock low for 2 cycles.
  - Response: state stays 3, loss_cnt=0.
- Lock loss in RUN:
  - Stimulus: in RUN, pll_lock low for 3 cycles.
  - Response: RESET_PLL, domain_rst=1, locked=0, loss_cnt=1.
- Lock drop in SETTLE:
  - Stimulus: pll_lock drops after 5 settle cycles.
  - Response: WAIT_LOCK with retry_cnt unchanged. Lock returns -> SETTLE restarts from 0 and needs a full 8 cycles.
- relock_req cases:
  - relock_req in FAULT -> RESET_PLL next edge, fault=0, retry_cnt=0.
  - relock_req in WAIT_LOCK -> ignored.
  - relock_req on the same edge as a qualified loss in RUN -> RESET_PLL, loss_cnt unchanged.
- Reset mid-sequence:
  - Stimulus: rst pulsed during SETTLE with retry_cnt=1.
  - Response: state=0, retry_cnt=0, loss_cnt=0, domain_rst=1, pll_resetb=0.

Source files
------------

// File: rtl/pll_lock_sequencer_if.sv
// pll_lock_sequencer_if
//   Groups the PLL-side and status signals of the lock sequencer into one bundle.
//   The master modport is the sequencer itself. The slave modport is whatever
//   surrounds it: the PLL primitive, the reset fan-out and status logic.
//
//   pll_lock   : PLL LOCK, asynchronous to the sequencer clock
//   relock_req : single-cycle request to restart the sequence from RUN or FAULT
//   pll_resetb : PLL RESETB, active low
//   pll_bypass : PLL BYPASS, which passes the reference clock through
//   domain_rst : active-high reset for the PLL-clocked logic
//   locked     : high only while the sequencer is in RUN
//   fault      : high only while the sequencer is in FAULT
//   state      : current state encoding
//   retry_cnt  : failed attempts since the last RUN or relock
//   loss_cnt   : lock-loss events, saturating at 255
interface pll_lock_sequencer_if #(
  parameter int MAX_RETRIES = 3
);
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  logic               pll_lock;
  logic               relock_req;
  logic               pll_resetb;
  logic               pll_bypass;
  logic               domain_rst;
  logic               locked;
  logic               fault;
  logic [2:0]         state;
  logic [RETRY_W-1:0] retry_cnt;
  logic [7:0]         loss_cnt;

  modport master (
    input  pll_lock, relock_req,
    output pll_resetb, pll_bypass, domain_rst, locked, fault,
           state, retry_cnt, loss_cnt
  );

  modport slave (
    output pll_lock, relock_req,
    input  pll_resetb, pll_bypass, domain_rst, locked, fault,
           state, retry_cnt, loss_cnt
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Brings up an SB_PLL40_CORE clock path. The block runs on the PLL reference
//   clock and drives PLL RESETB and BYPASS. It qualifies the asynchronous LOCK
//   signal and holds the PLL-clocked logic in reset until lock has been stable
//   long enough. When lock is lost, the block restarts the PLL. After repeated
//   failed attempts it parks in bypass so the reference clock still reaches the
//   downstream logic.
//
//   clk : reference clock, the same clock as PLL REFERENCECLK
//   rst : synchronous, active-high reset
//   bus : pll_lock_sequencer_if.master. It carries the PLL handshake and the
//         status outputs (see the interface file).
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int SETTLE_CYCLES = 1024,
  parameter int LOSS_FILTER   = 4,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  pll_lock_sequencer_if.master        bus
);

  localparam int RST_W    = $clog2(RST_CYCLES) + 1;
  localparam int LOCK_W   = $clog2(LOCK_TIMEOUT) + 1;
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES) + 1;
  localparam int LOSS_W   = $clog2(LOSS_FILTER) + 1;
  localparam int RETRY_W  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [RST_W-1:0]    RST_LAST    = RST_W'(RST_CYCLES - 1);
  localparam logic [LOCK_W-1:0]   LOCK_LAST   = LOCK_W'(LOCK_TIMEOUT - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [LOSS_W-1:0]   LOSS_LAST   = LOSS_W'(LOSS_FILTER - 1);
  localparam logic [RETRY_W-1:0]  RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t              state_q, state_n;
  logic [RST_W-1:0]    rst_tmr_q, rst_tmr_n;
  logic [LOCK_W-1:0]   lock_tmr_q, lock_tmr_n;
  logic [SETTLE_W-1:0] settle_q, settle_n;
  logic [LOSS_W-1:0]   loss_run_q, loss_run_n;
  logic [RETRY_W-1:0]  retry_q, retry_n;
  logic [7:0]          loss_cnt_q, loss_cnt_n;

  logic lock_meta, lock_s;
  logic resetb_q, resetb_n;
  logic bypass_q, bypass_n;
  logic domain_rst_q, domain_rst_n;
  logic locked_q, locked_n;
  logic fault_q, fault_n;

  // Two-flop synchronizer for the asynchronous LOCK output. The FSM looks only
  // at lock_s, so every lock decision has two cycles of extra latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= bus.pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // Next-state and counter logic. Each timer is cleared by the transition
  // that enters the state which uses it, so every state starts counting from
  // zero no matter where it was entered from.
  always_comb begin
    state_n    = state_q;
    rst_tmr_n  = rst_tmr_q;
    lock_tmr_n = lock_tmr_q;
    settle_n   = settle_q;
    loss_run_n = loss_run_q;
    retry_n    = retry_q;
    loss_cnt_n = loss_cnt_q;

    case (state_q)
      RESET_PLL: begin
        if (rst_tmr_q == RST_LAST) begin
          state_n    = WAIT_LOCK;
          lock_tmr_n = '0;
        end else begin
          rst_tmr_n = rst_tmr_q + 1'b1;
        end
      end

      WAIT_LOCK: begin
        if (lock_s) begin
          state_n  = SETTLE;
          settle_n = '0;
        end else if (lock_tmr_q == LOCK_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_n   = retry_q + 1'b1;
            state_n   = RESET_PLL;
            rst_tmr_n = '0;
          end else begin
            state_n = FAULT;
          end
        end else begin
          lock_tmr_n = lock_tmr_q + 1'b1;
        end
      end

      // A lock drop while settling sends the FSM back to waiting with a
      // fresh timeout. The drop is not counted as a failed attempt.
      SETTLE: begin
        if (!lock_s) begin
          state_n    = WAIT_LOCK;
          lock_tmr_n = '0;
        end else if (settle_q == SETTLE_LAST) begin
          state_n    = RUN;
          retry_n    = '0;
          loss_run_n = '0;
        end else begin
          settle_n = settle_q + 1'b1;
        end
      end

      // relock_req is checked before the loss filter, so a request that lands
      // on the same edge as a qualified loss does not count as a loss event.
      RUN: begin
        if (bus.relock_req) begin
          state_n   = RESET_PLL;
          retry_n   = '0;
          rst_tmr_n = '0;
        end else if (!lock_s) begin
          if (loss_run_q == LOSS_LAST) begin
            state_n   = RESET_PLL;
            rst_tmr_n = '0;
            if (loss_cnt_q != 8'hFF) begin
              loss_cnt_n = loss_cnt_q + 8'd1;
            end
          end else begin
            loss_run_n = loss_run_q + 1'b1;
          end
        end else begin
          loss_run_n = '0;
        end
      end

      FAULT: begin
        if (bus.relock_req) begin
          state_n   = RESET_PLL;
          retry_n   = '0;
          rst_tmr_n = '0;
        end
      end

      default: begin
        state_n   = RESET_PLL;
        rst_tmr_n = '0;
      end
    endcase
  end

  // The outputs are decoded from the next state and registered. They change
  // on the same edge as the state register and never glitch.
  always_comb begin
    resetb_n     = 1'b1;
    bypass_n     = 1'b0;
    domain_rst_n = 1'b1;
    locked_n     = 1'b0;
    fault_n      = 1'b0;
    case (state_n)
      RESET_PLL: resetb_n = 1'b0;
      RUN: begin
        domain_rst_n = 1'b0;
        locked_n     = 1'b1;
      end
      FAULT: begin
        resetb_n     = 1'b0;
        bypass_n     = 1'b1;
        domain_rst_n = 1'b0;
        fault_n      = 1'b1;
      end
      default: ;
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RESET_PLL;
      rst_tmr_q    <= '0;
      lock_tmr_q   <= '0;
      settle_q     <= '0;
      loss_run_q   <= '0;
      retry_q      <= '0;
      loss_cnt_q   <= '0;
      resetb_q     <= 1'b0;
      bypass_q     <= 1'b0;
      domain_rst_q <= 1'b1;
      locked_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_n;
      rst_tmr_q    <= rst_tmr_n;
      lock_tmr_q   <= lock_tmr_n;
      settle_q     <= settle_n;
      loss_run_q   <= loss_run_n;
      retry_q      <= retry_n;
      loss_cnt_q   <= loss_cnt_n;
      resetb_q     <= resetb_n;
      bypass_q     <= bypass_n;
      domain_rst_q <= domain_rst_n;
      locked_q     <= locked_n;
      fault_q      <= fault_n;
    end
  end

  assign bus.pll_resetb = resetb_q;
  assign bus.pll_bypass = bypass_q;
  assign bus.domain_rst = domain_rst_q;
  assign bus.locked     = locked_q;
  assign bus.fault      = fault_q;
  assign bus.state      = state_q;
  assign bus.retry_cnt  = retry_q;
  assign bus.loss_cnt   = loss_cnt_q;

endmodule
